time_set_controller: RTL and testbench
======================================

Name: time_set_controller

Overview:
- Write-side companion to the running clock display; the display only reads hours, minutes and seconds.
- Turns three raw pushbuttons (mode, inc, dec) into an edit session:
  - snapshots the current time;
  - lets the user step through hours, minutes and seconds and adjust each with wrap-around;
  - issues a one-cycle load pulse with the new time.
- Sits between the board buttons and the hour/minute/second counters' load inputs. It also drives the display mux and a blink flag.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples needed before a debounced level changes (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles an inc/dec button must be held after its press event before auto-repeat starts.
- REPEAT_PERIOD, 5000000: cycles between auto-repeat events while held.
- BLINK_CYCLES, 12500000: half-period of the blink output, in cycles.

Ports:
- Clock_50MHz  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_mode  input  1  raw mode button, active-high, asynchronous to the clock.
- btn_inc  input  1  raw increment button, active-high, asynchronous.
- btn_dec  input  1  raw decrement button, active-high, asynchronous.
- cur_hrs  input  5  live hour count, 0..23.
- cur_min  input  6  live minute count, 0..59.
- cur_sec  input  6  live second count, 0..59.
- set_active  output  1  high while an edit session is open.
- edit_field  output  2  field being edited: 0 none, 1 hours, 2 minutes, 3 seconds.
- edit_hrs  output  5  edited hour value; also the load data.
- edit_min  output  6  edited minute value; also the load data.
- edit_sec  output  6  edited second value; also the load data.
- blink  output  1  toggles every BLINK_CYCLES while set_active; 0 otherwise.
- load  output  1  one-cycle pulse; the counters take edit_* on this cycle.

Behaviour:
- Reset values: state RUN; all outputs 0; synchronizers, debounce counters, repeat timers and blink counter cleared; debounced levels 0.
- Input conditioning, per button:
  - 2-flop synchronizer, then debounce.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle clears the counter.
  - Press event: one-cycle pulse on the debounced 0->1 edge.
  - Latency: a clean raw rising edge sampled at cycle k gives an event at cycle k+2+DEBOUNCE_CYCLES.
- Auto-repeat (inc and dec only):
  - While the debounced level stays 1, one extra event fires REPEAT_DELAY cycles after the press event.
  - Further extra events fire every REPEAT_PERIOD cycles after that.
  - Release (debounced 0) stops repeat and clears the timer.
- State machine, one transition per mode event:
  - RUN -> EDIT_HRS: capture cur_hrs, cur_min, cur_sec into edit_* on the same edge; set_active=1; edit_field=1.
  - EDIT_HRS -> EDIT_MIN (edit_field=2).
  - EDIT_MIN -> EDIT_SEC (edit_field=3).
  - EDIT_SEC -> COMMIT.
  - COMMIT lasts exactly 1 cycle: load=1, set_active still 1, edit_* held. Next cycle returns to RUN: set_active=0, edit_field=0, edit_* keep their last values.
- Field updates: registered one cycle after the inc/dec event, on the field named by edit_field.
  - Hours: inc 23->0, dec 0->23.
  - Minutes and seconds: inc 59->0, dec 0->59.
  - Arithmetic is modulo field range; no out-of-range value ever appears on edit_*.
- Event priority and ignore rules:
  - inc and dec events in the same cycle: both ignored.
  - mode event in the same cycle as inc/dec: mode transition taken, inc/dec ignored.
  - inc/dec in RUN or COMMIT: ignored.
- Blink:
  - Counter runs only while set_active.
  - blink starts at 1 on session entry and toggles every BLINK_CYCLES.
  - Forced to 0 and counter cleared in RUN.
- Reset mid-session: immediate return to RUN on the next edge, no load pulse, edit_* cleared to 0.
- load never asserts outside COMMIT. At most one load per session.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK_CYCLES=8):
- Glitch rejection: btn_mode high for 3 cycles, then low -> no event; set_active stays 0. Held for 10 cycles -> set_active=1 at k+7 (event at k+6, registered next edge); edit_field=1.
- Full session: cur = 13:45:30; mode press; inc x2; mode press; dec x1; mode press; mode press -> edit_* = 15:44:30; load=1 for exactly 1 cycle; then set_active=0, edit_field=0.
- Wrap-around: hours 23 + inc -> 0; minutes 0 + dec -> 59; seconds 59 + inc -> 0.
- Auto-repeat: hold btn_inc 60 cycles while editing minutes from 10 -> events at press, +20, +25, +30 ... while held; final minutes = 10 + 1 + repeats counted by the bench. Release stops further changes.
- Simultaneous and priority: inc and dec events in the same cycle -> value unchanged. Mode and inc in the same cycle in EDIT_HRS -> moves to EDIT_MIN, hours unchanged.
- Reset mid-edit: assert reset in EDIT_MIN -> next cycle all outputs 0, load never pulses. A later session captures the fresh cur_* values.

Source files
------------

// File: rtl/time_set_controller.sv
// Time-set controller: conditions the mode/inc/dec pushbuttons and runs an
// edit session that snapshots the live time, adjusts hours/minutes/seconds
// with wrap-around, and hands the result to the counters with a load pulse.
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,  // must be >= 2
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic       Clock_50MHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hrs,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       set_active,
  output logic [1:0] edit_field,
  output logic [4:0] edit_hrs,
  output logic [5:0] edit_min,
  output logic [5:0] edit_sec,
  output logic       blink,
  output logic       load
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned BW   = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [2:0] {RUN, EDIT_HRS, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

  // Button index 0 = mode, 1 = inc, 2 = dec.
  logic [2:0] btn_raw;
  logic [2:0] press_evt;
  logic [2:1] rep_evt;

  assign btn_raw = {btn_dec, btn_inc, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          level_reg;
      logic          level_d_reg;
      logic          press_reg;
      logic [DW-1:0] cnt_reg;

      // Two-flop synchronizer, debounce counter and registered press pulse.
      always_ff @(posedge Clock_50MHz) begin
        if (reset) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
          press_reg   <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync1_reg   <= btn_raw[gi];
          sync2_reg   <= sync1_reg;
          level_d_reg <= level_reg;
          press_reg   <= level_reg & ~level_d_reg;
          if (sync2_reg != level_reg) begin
            if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
              level_reg <= sync2_reg;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + DW'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign press_evt[gi] = press_reg;

      if (gi != 0) begin : g_rep
        logic [TW-1:0] timer_reg;
        logic          armed_reg;
        logic          rep_reg;

        // Auto-repeat: first extra event REPEAT_DELAY after the press, then
        // every REPEAT_PERIOD; the timer only runs once the press was seen.
        always_ff @(posedge Clock_50MHz) begin
          if (reset || !level_reg) begin
            timer_reg <= '0;
            armed_reg <= 1'b0;
            rep_reg   <= 1'b0;
          end else if (press_reg) begin
            timer_reg <= TW'(REPEAT_DELAY - 2);
            armed_reg <= 1'b1;
            rep_reg   <= 1'b0;
          end else if (armed_reg && timer_reg == '0) begin
            timer_reg <= TW'(REPEAT_PERIOD - 1);
            rep_reg   <= 1'b1;
          end else if (armed_reg) begin
            timer_reg <= timer_reg - TW'(1);
            rep_reg   <= 1'b0;
          end else begin
            rep_reg <= 1'b0;
          end
        end

        // A release landing on the repeat cycle suppresses that repeat.
        assign rep_evt[gi] = rep_reg & level_reg;
      end
    end
  endgenerate

  logic ev_mode, ev_inc, ev_dec, adj_inc, adj_dec;

  assign ev_mode = press_evt[0];
  assign ev_inc  = press_evt[1] | rep_evt[1];
  assign ev_dec  = press_evt[2] | rep_evt[2];
  // Mode wins over inc/dec; inc together with dec cancels both.
  assign adj_inc = ev_inc & ~ev_dec & ~ev_mode;
  assign adj_dec = ev_dec & ~ev_inc & ~ev_mode;

  state_t        state_reg, state_next;
  logic [4:0]    hrs_reg, hrs_next;
  logic [5:0]    min_reg, min_next;
  logic [5:0]    sec_reg, sec_next;
  logic          blink_reg;
  logic [BW-1:0] blink_cnt_reg;

  // Session state and edited time registers.
  always_ff @(posedge Clock_50MHz) begin
    if (reset) begin
      state_reg <= RUN;
      hrs_reg   <= '0;
      min_reg   <= '0;
      sec_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hrs_reg   <= hrs_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
    end
  end

  // Next state, snapshot on session entry and wrap-around field adjustment.
  always_comb begin
    state_next = state_reg;
    hrs_next   = hrs_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    case (state_reg)
      RUN: begin
        if (ev_mode) begin
          state_next = EDIT_HRS;
          hrs_next   = cur_hrs;
          min_next   = cur_min;
          sec_next   = cur_sec;
        end
      end
      EDIT_HRS: begin
        if (ev_mode)      state_next = EDIT_MIN;
        else if (adj_inc) hrs_next = (hrs_reg >= 5'd23) ? 5'd0 : hrs_reg + 5'd1;
        else if (adj_dec) hrs_next = (hrs_reg == 5'd0 || hrs_reg > 5'd23) ? 5'd23 : hrs_reg - 5'd1;
      end
      EDIT_MIN: begin
        if (ev_mode)      state_next = EDIT_SEC;
        else if (adj_inc) min_next = (min_reg >= 6'd59) ? 6'd0 : min_reg + 6'd1;
        else if (adj_dec) min_next = (min_reg == 6'd0 || min_reg > 6'd59) ? 6'd59 : min_reg - 6'd1;
      end
      EDIT_SEC: begin
        if (ev_mode)      state_next = COMMIT;
        else if (adj_inc) sec_next = (sec_reg >= 6'd59) ? 6'd0 : sec_reg + 6'd1;
        else if (adj_dec) sec_next = (sec_reg == 6'd0 || sec_reg > 6'd59) ? 6'd59 : sec_reg - 6'd1;
      end
      COMMIT:  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Blink: starts high on entry, toggles every BLINK_CYCLES, low in RUN.
  always_ff @(posedge Clock_50MHz) begin
    if (reset || state_next == RUN) begin
      blink_reg     <= 1'b0;
      blink_cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      blink_reg     <= 1'b1;
      blink_cnt_reg <= '0;
    end else if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
      blink_reg     <= ~blink_reg;
      blink_cnt_reg <= '0;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BW'(1);
    end
  end

  // Field indicator decoded from the session state.
  always_comb begin
    edit_field = 2'd0;
    case (state_reg)
      EDIT_HRS: edit_field = 2'd1;
      EDIT_MIN: edit_field = 2'd2;
      EDIT_SEC: edit_field = 2'd3;
      default:  edit_field = 2'd0;
    endcase
  end

  assign set_active = (state_reg != RUN);
  assign load       = (state_reg == COMMIT);
  assign edit_hrs   = hrs_reg;
  assign edit_min   = min_reg;
  assign edit_sec   = sec_reg;
  assign blink      = blink_reg;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: button presses at transaction level against
// a field/time model derived from the press-to-event latency and repeat rules.
module tb_time_set_controller;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int BC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [4:0] cur_hrs = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic       set_active, blink, load;
  logic [1:0] edit_field;
  logic [4:0] edit_hrs;
  logic [5:0] edit_min, edit_sec;

  time_set_controller #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .BLINK_CYCLES(BC)
  ) dut (
    .Clock_50MHz(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hrs(cur_hrs), .cur_min(cur_min), .cur_sec(cur_sec),
    .set_active(set_active), .edit_field(edit_field),
    .edit_hrs(edit_hrs), .edit_min(edit_min), .edit_sec(edit_sec),
    .blink(blink), .load(load)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: field 0 = idle, 1..3 = hours/minutes/seconds.
  int m_field = 0, m_h = 0, m_m = 0, m_s = 0;
  int m_loads = 0, x_ld_h = 0, x_ld_m = 0, x_ld_s = 0;

  // Load monitor and per-cycle invariants.
  int   loads_seen = 0, ld_h = 0, ld_m = 0, ld_s = 0;
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (load) begin
        loads_seen++;
        ld_h = int'(edit_hrs);
        ld_m = int'(edit_min);
        ld_s = int'(edit_sec);
      end
      check("range", 32'((edit_hrs > 23) || (edit_min > 59) || (edit_sec > 59)), 0);
      check("blink_idle", 32'(!set_active && blink), 0);
      check("load_outside", 32'(load && !set_active), 0);
      check("load_width", 32'(load && prev_load), 0);
    end
    prev_load = load;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Events produced by one clean press held for 'hold' samples: the press
  // event plus repeats at RD, RD+RP, ... after it while the debounced level
  // (which lags the raw release by the same debounce latency) is still high.
  function automatic int n_events(input int hold);
    if (hold >= RD + 2) return 1 + (hold - RD - 2) / RP + 1;
    return 1;
  endfunction

  function automatic int wrap(input int v, input int range);
    return ((v % range) + range) % range;
  endfunction

  task automatic adjust(input int delta);
    case (m_field)
      1: m_h = wrap(m_h + delta, 24);
      2: m_m = wrap(m_m + delta, 60);
      3: m_s = wrap(m_s + delta, 60);
      default: ;
    endcase
  endtask

  task automatic mode_step();
    case (m_field)
      0: begin m_h = cur_hrs; m_m = cur_min; m_s = cur_sec; m_field = 1; end
      1, 2: m_field++;
      default: begin
        m_loads++; x_ld_h = m_h; x_ld_m = m_m; x_ld_s = m_s; m_field = 0;
      end
    endcase
  endtask

  task automatic compare_state(input string tag);
    check({tag, ".active"}, 32'(set_active), 32'(m_field != 0));
    check({tag, ".field"}, 32'(edit_field), m_field);
    check({tag, ".hrs"}, 32'(edit_hrs), m_h);
    check({tag, ".min"}, 32'(edit_min), m_m);
    check({tag, ".sec"}, 32'(edit_sec), m_s);
    check({tag, ".loads"}, loads_seen, m_loads);
    if (m_loads > 0) begin
      check({tag, ".ld_hrs"}, ld_h, x_ld_h);
      check({tag, ".ld_min"}, ld_m, x_ld_m);
      check({tag, ".ld_sec"}, ld_s, x_ld_s);
    end
  endtask

  // mask bit0 = mode, bit1 = inc, bit2 = dec, all pressed on the same cycle.
  task automatic press(input logic [2:0] mask, input int hold, input string tag);
    int n, delta;
    {btn_dec, btn_inc, btn_mode} = mask;
    tick(hold);
    {btn_dec, btn_inc, btn_mode} = 3'b000;
    tick(D + 8);
    n = n_events(hold);
    delta = 0;
    if (mask[1] && !mask[2]) delta = 1;
    if (mask[2] && !mask[1]) delta = -1;
    if (mask[0]) begin
      mode_step();
      adjust(delta * (n - 1));
    end else begin
      adjust(delta * n);
    end
    $display("press %s mask=%b hold=%0d -> field=%0d %0d:%0d:%0d loads=%0d",
             tag, mask, hold, edit_field, edit_hrs, edit_min, edit_sec, loads_seen);
    compare_state(tag);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hrs = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  initial begin
    logic [2:0] masks [4];
    masks[0] = 3'b001; masks[1] = 3'b010; masks[2] = 3'b100; masks[3] = 3'b110;

    tick(3);
    compare_state("reset");
    check("reset.blink", 32'(blink), 0);
    check("reset.load", 32'(load), 0);
    reset = 1'b0;
    tick(2);

    // Glitch shorter than the debounce window.
    btn_mode = 1'b1; tick(3); btn_mode = 1'b0; tick(15);
    compare_state("glitch");

    // Press latency and blink phase.
    set_cur(7, 8, 9);
    btn_mode = 1'b1;
    tick(7);
    check("latency.before", 32'(set_active), 0);
    tick(1);
    check("latency.active", 32'(set_active), 1);
    check("latency.field", 32'(edit_field), 1);
    check("blink.enter", 32'(blink), 1);
    tick(BC - 1);
    check("blink.hold", 32'(blink), 1);
    tick(1);
    check("blink.toggle", 32'(blink), 0);
    tick(BC);
    check("blink.toggle2", 32'(blink), 1);
    btn_mode = 1'b0;
    tick(D + 8);
    mode_step();
    compare_state("entry");
    press(3'b001, 5, "close1"); press(3'b001, 5, "close2"); press(3'b001, 5, "close3");

    // Full session 13:45:30 -> 15:44:30.
    set_cur(13, 45, 30);
    press(3'b001, 6, "full.mode");
    press(3'b010, 6, "full.inc1"); press(3'b010, 6, "full.inc2");
    press(3'b001, 6, "full.mode2");
    press(3'b100, 6, "full.dec");
    press(3'b001, 6, "full.mode3");
    press(3'b001, 6, "full.commit");
    check("full.ld", (ld_h << 16) | (ld_m << 8) | ld_s, (15 << 16) | (44 << 8) | 30);

    // Wrap-around on each field.
    set_cur(23, 0, 59);
    press(3'b001, 5, "wrap.enter");
    press(3'b010, 5, "wrap.hrs");
    check("wrap.hrs0", 32'(edit_hrs), 0);
    press(3'b001, 5, "wrap.tomin");
    press(3'b100, 5, "wrap.min");
    check("wrap.min59", 32'(edit_min), 59);
    press(3'b001, 5, "wrap.tosec");
    press(3'b010, 5, "wrap.sec");
    check("wrap.sec0", 32'(edit_sec), 0);
    press(3'b001, 5, "wrap.commit");

    // Auto-repeat on minutes, then no change after release.
    set_cur(4, 10, 0);
    press(3'b001, 5, "rep.enter"); press(3'b001, 5, "rep.tomin");
    press(3'b010, 60, "rep.hold");
    check("rep.value", 32'(edit_min), 19);
    tick(30);
    compare_state("rep.after");

    // Simultaneous inc+dec, then mode+inc in hours.
    press(3'b110, 8, "simul");
    press(3'b001, 5, "rep.tosec"); press(3'b001, 5, "rep.commit");
    set_cur(5, 6, 7);
    press(3'b001, 5, "prio.enter");
    press(3'b011, 10, "prio.modeinc");
    check("prio.hrs", 32'(edit_hrs), 5);

    // Reset during minutes edit, then a fresh session.
    @(posedge clk); #1;
    reset = 1'b1; tick(1);
    m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    compare_state("rst.mid");
    check("rst.blink", 32'(blink), 0);
    check("rst.load", 32'(load), 0);
    reset = 1'b0; tick(2);
    set_cur(21, 33, 44);
    press(3'b001, 5, "rst.fresh");

    // Randomized presses.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] mk;
      int hold;
      mk = masks[$urandom_range(0, 3)];
      hold = (mk == 3'b001) ? int'($urandom_range(4, 12)) : int'($urandom_range(4, 45));
      set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      press(mk, hold, "rand");
    end
    while (m_field != 0) press(3'b001, 5, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
